// File: rtl/dzcpu_useq.sv
// Micro-op sequencer: latches the fetched mOp, loads uPC from the LUT, walks the uop ROM by flow code.
// Optional trace counters are enabled with `define DZCPU_USEQ_TRACE_EN.
module dzcpu_useq #(
    parameter int UOP_W    = 12,
    parameter int FLOW_W   = 3,
    parameter int OPC_W    = 5,
    parameter int OPR_W    = 4,
    parameter int MAX_UOPS = 32
) (
    input  logic             iClock,
    input  logic             iReset,
    input  logic             iStall,
    input  logic [7:0]       iMemData,
    input  logic [7:0]       iLutIdx,
    input  logic [7:0]       iCbLutIdx,
    input  logic [UOP_W-1:0] iUop,
    input  logic             iZero,
    output logic [7:0]       oMop,
    output logic [7:0]       oUopAddr,
    output logic             oUopValid,
    output logic [OPC_W-1:0] oOpc,
    output logic [OPR_W-1:0] oOpr,
    output logic             oIncPc,
    output logic             oMopDone,
    output logic             oUcodeErr,
    output logic [15:0]      oTraceCnt,
    output logic [7:0]       oTraceMop
);

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;

    localparam logic [FLOW_W-1:0] FL_OP        = FLOW_W'(0);
    localparam logic [FLOW_W-1:0] FL_INC       = FLOW_W'(1);
    localparam logic [FLOW_W-1:0] FL_EOF       = FLOW_W'(2);
    localparam logic [FLOW_W-1:0] FL_INC_EOF   = FLOW_W'(3);
    localparam logic [FLOW_W-1:0] FL_INC_EOF_Z = FLOW_W'(4);
    localparam logic [FLOW_W-1:0] FL_JCB       = FLOW_W'(5);

    localparam logic [7:0] CNT_LAST = 8'(MAX_UOPS - 1);

    logic [1:0]        state, state_nxt;
    logic [7:0]        upc, upc_nxt;
    logic [7:0]        count;
    logic [FLOW_W-1:0] flow;
    logic              uop_valid, inc_pc, mop_done, err_set, terminal;

    assign flow      = iUop[UOP_W-1 -: FLOW_W];
    assign oOpc      = iUop[OPC_W+OPR_W-1 : OPR_W];
    assign oOpr      = iUop[OPR_W-1:0];
    assign oUopAddr  = upc;
    assign oUopValid = uop_valid;
    assign oIncPc    = inc_pc;
    assign oMopDone  = mop_done;

    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        uop_valid = 1'b0;
        inc_pc    = 1'b0;
        mop_done  = 1'b0;
        err_set   = 1'b0;
        terminal  = 1'b0;
        upc_nxt   = upc;
        state_nxt = state;
        case (state)
            ST_FETCH:  state_nxt = ST_DECODE;
            ST_DECODE: begin
                upc_nxt   = iLutIdx;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                uop_valid = 1'b1;
                case (flow)
                    FL_OP:  upc_nxt = upc + 8'd1;
                    FL_INC: begin
                        inc_pc  = 1'b1;
                        upc_nxt = upc + 8'd1;
                    end
                    FL_EOF: begin
                        mop_done = 1'b1;
                        terminal = 1'b1;
                    end
                    FL_INC_EOF: begin
                        inc_pc   = 1'b1;
                        mop_done = 1'b1;
                        terminal = 1'b1;
                    end
                    FL_INC_EOF_Z: begin
                        inc_pc = 1'b1;
                        if (iZero) begin
                            uop_valid = 1'b0;
                            mop_done  = 1'b1;
                            terminal  = 1'b1;
                        end else begin
                            upc_nxt = upc + 8'd1;
                        end
                    end
                    FL_JCB: begin
                        inc_pc  = 1'b1;
                        upc_nxt = iCbLutIdx;
                    end
                    default: begin
                        err_set  = 1'b1;
                        mop_done = 1'b1;
                        terminal = 1'b1;
                    end
                endcase
                // Runaway guard: the last permitted uop must retire the mOp itself.
                if (!terminal && count == CNT_LAST) begin
                    err_set  = 1'b1;
                    mop_done = 1'b1;
                    terminal = 1'b1;
                end
                if (terminal) state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_FETCH;
        endcase
        if (iStall) begin
            uop_valid = 1'b0;
            inc_pc    = 1'b0;
            mop_done  = 1'b0;
            err_set   = 1'b0;
            upc_nxt   = upc;
            state_nxt = state;
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state     <= ST_FETCH;
            upc       <= 8'd0;
            count     <= 8'd0;
            oMop      <= 8'h00;
            oUcodeErr <= 1'b0;
        end else begin
            state <= state_nxt;
            upc   <= upc_nxt;
            if (!iStall) begin
                if (state == ST_FETCH) oMop <= iMemData;
                if (state == ST_DECODE) count <= 8'd0;
                else if (state == ST_EXEC) count <= count + 8'd1;
            end
            if (err_set) oUcodeErr <= 1'b1;
        end
    end

`ifdef DZCPU_USEQ_TRACE_EN
    logic [15:0] trace_cnt;
    logic [7:0]  trace_mop;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            trace_cnt <= 16'd0;
            trace_mop <= 8'd0;
        end else if (mop_done) begin
            trace_cnt <= trace_cnt + 16'd1;
            trace_mop <= oMop;
        end
    end

    assign oTraceCnt = trace_cnt;
    assign oTraceMop = trace_mop;
`else
    assign oTraceCnt = 16'd0;
    assign oTraceMop = 8'd0;
`endif

endmodule
